mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Synthesizable memory target that answers the multicycle RV32I core's memory initiator port on the same signal set: mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, mem_rdata and mem_resp.
- Services one word-wide request at a time, after a fixed programmable latency, from an internal word array.
- Used as the backing memory in core-level simulation and as the on-chip memory for FPGA bring-up.

Parameters:
- ADDR_BITS, 10: word-address width; the array holds 2**ADDR_BITS 32-bit words.
- LATENCY, 3: cycles from request acceptance to mem_resp. Legal range is 1..15; any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_read  input  1  read request; held by the initiator until mem_resp.
- mem_write  input  1  write request; held by the initiator until mem_resp.
- mem_byte_enable  input  4  write byte lanes; bit i selects wdata[8i+7:8i].
- mem_address  input  32  byte address; bits [1:0] ignored.
- mem_wdata  input  32  write data.
- mem_rdata  output  32  read data; valid in the mem_resp cycle of a read.
- mem_resp  output  1  one-cycle completion pulse.
- mem_err  output  1  one-cycle error pulse, coincident with mem_resp.

Behaviour:
- States: IDLE, BUSY, RESP. Reset sends state to IDLE and clears mem_rdata, mem_resp, mem_err and the latency counter to 0. Array contents are not cleared.
- Acceptance:
  - In IDLE, mem_read|mem_write high at a rising edge latches address, wdata, byte_enable and op.
  - Request inputs are ignored until the state returns to IDLE.
- Transitions:
  - IDLE goes to BUSY with the counter loaded to LATENCY-1. If LATENCY==1, IDLE goes directly to RESP.
  - BUSY decrements the counter each cycle; at counter==1 the next state is RESP.
  - RESP goes to IDLE unconditionally.
  - With the request sampled high at edge k, mem_resp is high for exactly the cycle between edges k+LATENCY and k+LATENCY+1.
- Read:
  - mem_rdata is registered on entry to RESP with array[addr[ADDR_BITS+1:2]].
  - mem_rdata holds its value until the next read response.
- Write:
  - The array word is updated at the edge leaving RESP, lane by lane per the latched byte_enable.
  - byte_enable=0000 completes normally with no change.
  - mem_rdata is unchanged by a write.
- Out of range: if mem_address[31:ADDR_BITS+2] != 0:
  - mem_err pulses with mem_resp;
  - a write is dropped;
  - a read returns 0.
- Illegal op: mem_read and mem_write both high at acceptance:
  - mem_err pulses with mem_resp;
  - no array write occurs;
  - mem_rdata is unchanged.
- Back-to-back: a request still high in the cycle after mem_resp (IDLE) is accepted as a new transaction. The minimum spacing between responses is LATENCY+1 cycles.
- Reset mid-transaction: abort immediately and return to IDLE. No write is committed, mem_resp stays 0, and the latched request is discarded.
- Mid-transaction changes to address/data/op inputs have no effect.

Decomposition:
- Add mem_resp_state_t (IDLE, BUSY, RESP) to the shared rv32i_types package, alongside a MEM_WORD_BYTES=4 constant.
- One sub-module: mem_byte_merge (combinational). Inputs: old word, new word, 4-bit enable. Output: the merged word written back to the array.

Test Plan:
- LATENCY=3. Write 0xDEADBEEF to 0x00000010 with be=1111, then read 0x00000010 -> mem_resp exactly 3 cycles after each acceptance; read returns 0xDEADBEEF; mem_err=0.
- Preload 0x11223344 at 0x20. Write 0xAABBCCDD with be=0101 -> read returns 0x11BB33DD.
- Read 0x00001000 with ADDR_BITS=10 (out of range) -> mem_resp and mem_err together; mem_rdata=0. A following write to 0x1000 leaves word 0 unchanged.
- mem_read=mem_write=1 at 0x4, with mem_rdata previously 0xCAFEF00D -> mem_err pulse; mem_rdata stays 0xCAFEF00D; word 1 unchanged.
- Assert rst two cycles into a write of 0x12345678 to 0x8 -> mem_resp never asserts; all outputs are 0 after reset; a read of 0x8 returns the prior contents.
- LATENCY=1, with mem_read held high continuously on 0x10 -> mem_resp high every other cycle, each pulse returning 0xDEADBEEF.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the RV32I core memory subsystem.
//   MEM_WORD_BYTES   : byte lanes per memory word
//   mem_resp_state_t : state of the memory responder
//   mem_req_t        : request fields captured at acceptance
package rv32i_types;

    localparam int MEM_WORD_BYTES = 4;
    localparam int MEM_WORD_BITS  = MEM_WORD_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    // Word address only: the byte offset in address[1:0] is never used.
    typedef struct packed {
        logic                      rd;
        logic                      wr;
        logic [29:0]               waddr;
        logic [MEM_WORD_BITS-1:0]  wdata;
        logic [MEM_WORD_BYTES-1:0] be;
    } mem_req_t;

endpackage

// File: rtl/mem_byte_merge.sv
// Byte-lane merge of a write into an existing memory word.
//   old_word : current array contents
//   new_word : write data
//   byte_en  : lane i takes new_word[8i+7:8i] when set, else keeps old_word
//   merged   : word written back to the array
module mem_byte_merge
    import rv32i_types::*;
(
    input  logic [MEM_WORD_BITS-1:0]  old_word,
    input  logic [MEM_WORD_BITS-1:0]  new_word,
    input  logic [MEM_WORD_BYTES-1:0] byte_en,
    output logic [MEM_WORD_BITS-1:0]  merged
);

    for (genvar i = 0; i < MEM_WORD_BYTES; i++) begin : g_lane
        assign merged[8*i +: 8] = byte_en[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory target for the multicycle RV32I core memory port.
// One request at a time; mem_resp/mem_err pulse LATENCY cycles after the
// accepting edge.
//   clk, rst         : clock, async active-high reset
//   mem_read/write   : request strobes, held until mem_resp
//   mem_byte_enable  : write byte lanes
//   mem_address      : byte address (bits [1:0] ignored)
//   mem_wdata        : write data
//   mem_rdata        : read data, valid during mem_resp of a read
//   mem_resp         : one-cycle completion pulse
//   mem_err          : one-cycle error pulse (out of range or read+write)
module mem_responder
    import rv32i_types::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [MEM_WORD_BYTES-1:0] mem_byte_enable,
    input  logic [31:0]               mem_address,
    input  logic [MEM_WORD_BITS-1:0]  mem_wdata,
    output logic [MEM_WORD_BITS-1:0]  mem_rdata,
    output logic                      mem_resp,
    output logic                      mem_err
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_responder: LATENCY must be in 1..15");
    end

    mem_resp_state_t state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    mem_req_t        req_q, req_in, req_src;

    logic [MEM_WORD_BITS-1:0] mem_array [0:(1<<ADDR_BITS)-1];
    logic [MEM_WORD_BITS-1:0] merged_word;
    logic                     accept;
    logic                     src_oor, q_oor, q_illegal;
    logic                     addr_lsb_unused;

    assign addr_lsb_unused = ^mem_address[1:0];

    assign req_in = '{rd: mem_read, wr: mem_write, waddr: mem_address[31:2],
                      wdata: mem_wdata, be: mem_byte_enable};

    // With LATENCY==1 RESP is entered on the accepting edge itself, so the
    // read data must come from the live inputs rather than the latched copy.
    assign req_src   = (state_q == IDLE) ? req_in : req_q;
    assign src_oor   = |req_src.waddr[29:ADDR_BITS];
    assign q_oor     = |req_q.waddr[29:ADDR_BITS];
    assign q_illegal = req_q.rd & req_q.wr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_read | mem_write) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // mem_resp/mem_err are registered from the RESP state, so the pulse
    // lands in the cycle after RESP; that IDLE cycle can already accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            mem_rdata <= '0;
            mem_resp  <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            if (accept) req_q <= req_in;
            mem_resp <= (state_q == RESP);
            mem_err  <= (state_q == RESP) && (q_oor || q_illegal);
            if (state_d == RESP && state_q != RESP && req_src.rd && !req_src.wr)
                mem_rdata <= src_oor ? '0 : mem_array[req_src.waddr[ADDR_BITS-1:0]];
        end
    end

    mem_byte_merge u_merge (
        .old_word (mem_array[req_q.waddr[ADDR_BITS-1:0]]),
        .new_word (req_q.wdata),
        .byte_en  (req_q.be),
        .merged   (merged_word)
    );

    // Commit on the edge leaving RESP; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RESP && req_q.wr && !req_q.rd && !q_oor)
            mem_array[req_q.waddr[ADDR_BITS-1:0]] <= merged_word;
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_read, m_write, l_read, l_write;
    logic [3:0]  m_be, l_be;
    logic [31:0] m_addr, m_wdata, m_rdata, l_addr, l_wdata, l_rdata;
    logic        m_resp, m_err, l_resp, l_err;

    mem_responder #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .mem_read(m_read), .mem_write(m_write),
        .mem_byte_enable(m_be), .mem_address(m_addr), .mem_wdata(m_wdata),
        .mem_rdata(m_rdata), .mem_resp(m_resp), .mem_err(m_err));

    mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .mem_read(l_read), .mem_write(l_write),
        .mem_byte_enable(l_be), .mem_address(l_addr), .mem_wdata(l_wdata),
        .mem_rdata(l_rdata), .mem_resp(l_resp), .mem_err(l_err));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q0[$], q1[$];
    exp_t e0, e1;
    logic [31:0] mdl [16];      // reference contents of words 0..15
    logic [31:0] mdl_rdata;     // what the main DUT's mem_rdata should hold

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: pop an expectation whenever a response appears.
    always @(negedge clk) if (!rst) begin
        if (m_resp) begin
            if (q0.size() == 0) chk("m_unexpected_resp", 1, 0);
            else begin
                e0 = q0.pop_front();
                chk("m_resp_cycle", cyc, e0.cyc);
                chk("m_err", {31'd0, m_err}, {31'd0, e0.err});
                chk("m_rdata", m_rdata, e0.rdata);
            end
        end else begin
            if (m_err) chk("m_err_without_resp", 1, 0);
            if (q0.size() != 0 && cyc > q0[0].cyc) begin
                chk("m_resp_missing", cyc, q0[0].cyc);
                void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) if (!rst) begin
        if (l_resp) begin
            if (q1.size() == 0) chk("l1_unexpected_resp", 1, 0);
            else begin
                e1 = q1.pop_front();
                chk("l1_resp_cycle", cyc, e1.cyc);
                chk("l1_err", {31'd0, l_err}, {31'd0, e1.err});
                chk("l1_rdata", l_rdata, e1.rdata);
            end
        end else begin
            if (l_err) chk("l1_err_without_resp", 1, 0);
            if (q1.size() != 0 && cyc > q1[0].cyc) begin
                chk("l1_resp_missing", cyc, q1[0].cyc);
                void'(q1.pop_front());
            end
        end
    end

    // Issue one request on the main DUT, push its expectation, hold it
    // (scrambling the non-strobe inputs) until mem_resp, then release.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        logic oor, ill;
        int   w;
        bit   seen;
        @(negedge clk);
        m_read = rd; m_write = wr; m_addr = addr; m_wdata = wdata; m_be = be;
        oor = (addr[31:12] != 20'd0);
        ill = rd && wr;
        w   = int'(addr[5:2]);
        if (!ill) begin
            if (rd) mdl_rdata = oor ? 32'd0 : mdl[w];
            else if (!oor)
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[w][8*b +: 8] = wdata[8*b +: 8];
        end
        q0.push_back('{cyc + 1 + LAT, mdl_rdata, oor || ill});
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (m_resp) seen = 1;
            else begin
                m_addr = $urandom; m_wdata = $urandom; m_be = 4'($urandom);
            end
        end
        m_read = 0; m_write = 0;
    endtask

    initial begin
        int n;
        logic [31:0] a;
        rst = 1;
        m_read = 0; m_write = 0; m_be = 0; m_addr = 0; m_wdata = 0;
        l_read = 0; l_write = 0; l_be = 0; l_addr = 0; l_wdata = 0;
        mdl_rdata = 0;
        repeat (3) @(negedge clk);
        chk("reset_resp", {31'd0, m_resp}, 0);
        chk("reset_err", {31'd0, m_err}, 0);
        chk("reset_rdata", m_rdata, 0);
        rst = 0;

        for (int w = 0; w < 16; w++) do_req(0, 1, 32'(w * 4), $urandom, 4'hF);

        do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req(1, 0, 32'h10, 32'h0, 4'h0);
        chk("read_deadbeef", m_rdata, 32'hDEADBEEF);

        do_req(0, 1, 32'h20, 32'h11223344, 4'hF);
        do_req(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
        do_req(1, 0, 32'h20, 32'h0, 4'h0);
        chk("byte_merge", m_rdata, 32'h11BB33DD);

        do_req(0, 1, 32'h24, 32'h55555555, 4'b0000);
        do_req(1, 0, 32'h1000, 32'h0, 4'h0);
        chk("oor_read_zero", m_rdata, 32'h0);
        do_req(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        do_req(1, 0, 32'h0, 32'h0, 4'h0);

        do_req(0, 1, 32'h30, 32'hCAFEF00D, 4'hF);
        do_req(1, 0, 32'h30, 32'h0, 4'h0);
        do_req(1, 1, 32'h4, 32'h99999999, 4'hF);
        chk("illegal_keeps_rdata", m_rdata, 32'hCAFEF00D);
        do_req(1, 0, 32'h4, 32'h0, 4'h0);

        // Reset two cycles into a write: nothing commits, no response.
        do_req(0, 1, 32'h8, 32'h0BADC0DE, 4'hF);
        @(negedge clk);
        m_write = 1; m_addr = 32'h8; m_wdata = 32'h12345678; m_be = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1;
        #1;
        chk("midreset_resp", {31'd0, m_resp}, 0);
        chk("midreset_err", {31'd0, m_err}, 0);
        chk("midreset_rdata", m_rdata, 0);
        mdl_rdata = 0;
        @(negedge clk);
        m_write = 0;
        rst = 0;
        repeat (6) @(negedge clk);
        do_req(1, 0, 32'h8, 32'h0, 4'h0);
        chk("read_after_abort", m_rdata, 32'h0BADC0DE);

        for (int i = 0; i < 150; i++) begin
            n = int'($urandom_range(0, 9));
            a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            if (n == 9) a = $urandom | 32'h1000;
            if (n < 4)       do_req(1, 0, a, $urandom, 4'($urandom));
            else if (n < 8)  do_req(0, 1, a, $urandom, 4'($urandom));
            else if (n == 8) do_req(1, 1, a, $urandom, 4'($urandom));
            else             do_req(n[0] ? 1'b1 : 1'b0, n[0] ? 1'b0 : 1'b1, a, $urandom, 4'($urandom));
        end

        // LATENCY=1 instance: one write, then a read held high continuously.
        @(negedge clk);
        l_write = 1; l_addr = 32'h10; l_wdata = 32'hDEADBEEF; l_be = 4'hF;
        q1.push_back('{cyc + 2, 32'h0, 1'b0});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (l_resp) break;
        end
        l_write = 0;
        @(negedge clk);
        l_read = 1;
        for (int i = 0; i < 6; i++) q1.push_back('{cyc + 2 + 2 * i, 32'hDEADBEEF, 1'b0});
        n = 0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            @(negedge clk);
            if (l_resp) n++;
        end
        l_read = 0;

        repeat (8) @(negedge clk);
        chk("m_queue_drained", q0.size(), 0);
        chk("l1_queue_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
